// File: rtl/multicycle_logic_unit_pkg.sv
// Shared types for the multicycle logic unit: operation codes and FSM states.
package multicycle_logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_ORN  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter width: ceil(log2(n)), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_logic_unit_bit_logic_slice.sv
// Combinational bitwise operator applied to one SLICE-wide chunk of the operands.
module bit_logic_slice
  import multicycle_logic_unit_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  op_e              op,
  output logic [SLICE-1:0] y
);

  // Select the bitwise function for this slice.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_ORN:  y = a | ~b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_logic_unit.sv
// Bitwise logic unit that processes its operands one SLICE per clock.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for ctrl_start
// RUN     | one slice per edge; last slice loads the result
// DONE    | result valid, one-cycle ready pulse; may accept next start
module multicycle_logic_unit
  import multicycle_logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_zero,
  output logic             busy
);

  localparam int N  = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("multicycle_logic_unit: WIDTH must be a positive multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic             load, step, finish;
  logic [CW-1:0]    cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [SLICE-1:0] a_slice, b_slice, r_slice;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ctrl_start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pick the operand slice addressed by the counter.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_slice = a_q[i*SLICE +: SLICE];
        b_slice = b_q[i*SLICE +: SLICE];
      end
    end
  end

  bit_logic_slice #(.SLICE(SLICE)) u_slice (
    .a  (a_slice),
    .b  (b_slice),
    .op (op_q),
    .y  (r_slice)
  );

  // Accumulator with the current slice result merged in; on the last slice this is the full result.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) acc_d[i*SLICE +: SLICE] = r_slice;
    end
  end

  // Operand latch, slice counter, accumulator and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (load) begin
        op_q  <= op_e'(op);
        a_q   <= data_operandA;
        b_q   <= data_operandB;
        cnt_q <= '0;
      end else if (step) begin
        acc_q <= acc_d;
        // Counter parks on the last slice rather than wrapping.
        if (!finish) cnt_q <= cnt_q + CW'(1);
      end
      if (finish) begin
        result_q <= acc_d;
        zero_q   <= (acc_d == '0);
      end
    end
  end

  assign data_result    = result_q;
  assign data_zero      = zero_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q == ST_RUN);

endmodule
